// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor.
// It supports add, subtract, add-with-carry and signed saturating add, and
// reports carry-out and signed overflow. Valid/ready handshakes on both sides.
// Rank 1 registers the decoded operands. The remaining STAGES-1 ranks sit on
// prefix-level boundaries and are spread as evenly as possible. The final
// carry/sum/saturation logic is combinational from the last rank. Latency is
// therefore STAGES edges from acceptance to out_valid.
// The whole pipeline advances as one unit. Bubbles are never compressed, so
// ordering and latency stay trivially fixed.

module prefix_adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SAT = 2'b11;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

    // Everything one prefix level hands to the next.
    // - g/p are the group generate/propagate values, which span further each level.
    // - pb is the untouched bitwise propagate, needed for the final sum XOR.
    // - c0, sat and a_msb ride along for the carry-in and saturation logic
    //   after the last level.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] pb;
        logic             c0;
        logic             sat;
        logic             a_msb;
    } lvl_t;

    // True when a pipeline rank sits right after prefix level k.
    // Rank r (1..STAGES-1) lands on level floor(r*LEVELS/(STAGES-1)). The ranks
    // therefore spread evenly, and the last one always closes level LEVELS.
    function automatic bit reg_after(input int k);
        bit hit;
        hit = 1'b0;
        for (int r_i = 1; r_i < STAGES; r_i++) begin
            if ((r_i * LEVELS) / (STAGES - 1) == k) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Global advance: every rank moves together unless the output is stuck.
    logic advance;

    // Decoded operand controls for the beat currently offered.
    logic [WIDTH-1:0] b_eff_next;
    logic             c0_next;
    logic             sat_next;

    // Rank 1 state.
    logic             r1_valid_reg;
    logic [WIDTH-1:0] r1_a_reg;
    logic [WIDTH-1:0] r1_b_reg;
    logic             r1_c0_reg;
    logic             r1_sat_reg;

    // Decode op into inverted-B / carry-in / saturate controls.
    // cin only reaches the datapath for add-with-carry.
    always_comb begin
        b_eff_next = b_in;
        c0_next    = 1'b0;
        sat_next   = 1'b0;
        case (op)
            OP_ADD: begin
                b_eff_next = b_in;
            end
            OP_SUB: begin
                b_eff_next = ~b_in;
                c0_next    = 1'b1;
            end
            OP_ADC: begin
                c0_next = cin;
            end
            OP_SAT: begin
                sat_next = SAT_EN;
            end
            default: begin
                b_eff_next = b_in;
            end
        endcase
    end

    // Rank 1 captures decoded operands on an accepted beat.
    // On a bubble only the valid bit drops, so data holds.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r1_valid_reg <= 1'b0;
            r1_a_reg     <= '0;
            r1_b_reg     <= '0;
            r1_c0_reg    <= 1'b0;
            r1_sat_reg   <= 1'b0;
        end else if (advance) begin
            if (in_valid) begin
                r1_valid_reg <= 1'b1;
                r1_a_reg     <= a_in;
                r1_b_reg     <= b_eff_next;
                r1_c0_reg    <= c0_next;
                r1_sat_reg   <= sat_next;
            end else begin
                r1_valid_reg <= 1'b0;
            end
        end
    end

    // Level 0 forms bitwise generate/propagate.
    // Levels 1..LEVELS are Kogge-Stone combine steps with span 2^(level-1).
    // Each level output is either registered or passed straight through.
    for (genvar gi = 0; gi <= LEVELS; gi++) begin : lv
        lvl_t d;
        lvl_t q;

        if (gi == 0) begin : g_leaf
            // Bitwise generate/propagate from the rank 1 operands.
            always_comb begin
                d.valid = r1_valid_reg;
                d.g     = r1_a_reg & r1_b_reg;
                d.p     = r1_a_reg ^ r1_b_reg;
                d.pb    = r1_a_reg ^ r1_b_reg;
                d.c0    = r1_c0_reg;
                d.sat   = r1_sat_reg;
                d.a_msb = r1_a_reg[WIDTH-1];
            end
        end else begin : g_step
            localparam int DIST = 1 << (gi - 1);
            // Bits below DIST already hold complete groups down to bit 0 and
            // keep their propagate unchanged.
            localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - DIST);

            lvl_t prev;
            assign prev = lv[gi-1].q;

            // One prefix combine: (G,P)[i] o (G,P)[i-DIST].
            always_comb begin
                d   = prev;
                d.g = prev.g | (prev.p & (prev.g << DIST));
                d.p = prev.p & ((prev.p << DIST) | LOW_MASK);
            end
        end

        if (reg_after(gi)) begin : g_rank
            // Pipeline rank: load data only for a valid beat so outputs hold
            // across bubbles; valid always follows the upstream rank.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    q <= '0;
                end else if (advance) begin
                    if (d.valid) begin
                        q <= d;
                    end else begin
                        q.valid <= 1'b0;
                    end
                end
            end
        end else begin : g_wire
            assign q = d;
        end
    end

    lvl_t             fin;
    logic [WIDTH-1:0] carry_vec;
    logic [WIDTH-1:0] raw_sum;
    logic             carry_out;
    logic             ovf_raw;

    assign fin = lv[LEVELS].q;

    // Carry into bit i is G[i-1:0] | (P[i-1:0] & c0). Bit 0 gets c0 itself.
    assign carry_vec = {fin.g[WIDTH-2:0] | (fin.p[WIDTH-2:0] & {(WIDTH-1){fin.c0}}), fin.c0};
    assign carry_out = fin.g[WIDTH-1] | (fin.p[WIDTH-1] & fin.c0);
    assign raw_sum   = fin.pb ^ carry_vec;
    assign ovf_raw   = carry_vec[WIDTH-1] ^ carry_out;

    // Saturating add clamps toward the sign of A when the signed result wrapped.
    always_comb begin
        sum = raw_sum;
        if (fin.sat && ovf_raw) begin
            sum = fin.a_msb ? MIN_NEG : MAX_POS;
        end
    end

    assign cout      = carry_out;
    assign ovf       = ovf_raw;
    assign out_valid = fin.valid;
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe.
// The main instance (WIDTH=8, STAGES=2) gets these directed checks:
// - a table of hand-computed vectors,
// - a backpressure stream,
// - a mid-stream reset sequence.
// Several extra WIDTH/STAGES instances run random handshaked traffic against a
// behavioural model.

module tb_prefix_adder_pipe;

    localparam int W    = 8;
    localparam int S    = 2;
    localparam int NV   = 16;
    localparam int NCFG = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int tests_run    = 0;
    int tests_failed = 0;
    int sweeps_done  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [1:0] o;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs [NV];

    prefix_adder_pipe #(.WIDTH(W), .STAGES(S), .SAT_EN(1'b1)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference result packed as {cout, ovf, sum}.
    // It uses plain wide arithmetic and the sign rule for overflow.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input logic [1:0] o);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bx;
        logic [63:0] s;
        logic [65:0] wide;
        logic        c0;
        logic        co;
        logic        ov;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bx   = (o == 2'b01) ? (~b & mask) : (b & mask);
        c0   = (o == 2'b01) ? 1'b1 : ((o == 2'b10) ? c : 1'b0);
        wide = {2'b00, am} + {2'b00, bx} + {65'd0, c0};
        s    = wide[63:0] & mask;
        co   = wide[w];
        ov   = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
        if (o == 2'b11 && ov) begin
            s = am[w-1] ? (64'd1 << (w - 1)) : (mask >> 1);
        end
        return {co, ov, s};
    endfunction

    function automatic int cfg_w(input int i);
        case (i)
            0: return 4;
            1: return 4;
            2: return 8;
            3: return 32;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0: return 1;
            1: return 3;
            2: return 4;
            3: return 2;
            default: return 6;
        endcase
    endfunction

    // Random sweep instances, each with its own reset and handshake traffic.
    for (genvar gi = 0; gi < NCFG; gi++) begin : sweep
        localparam int SW = cfg_w(gi);
        localparam int SS = cfg_s(gi);

        logic          s_rst;
        logic          s_iv;
        logic          s_ir;
        logic          s_ci;
        logic          s_ov;
        logic          s_or;
        logic          s_co;
        logic          s_of;
        logic [SW-1:0] s_a;
        logic [SW-1:0] s_b;
        logic [SW-1:0] s_sum;
        logic [1:0]    s_op;

        prefix_adder_pipe #(.WIDTH(SW), .STAGES(SS), .SAT_EN(1'b1)) dut_s (
            .wb_clk_i (clk),
            .wb_rst_i (s_rst),
            .in_valid (s_iv),
            .in_ready (s_ir),
            .a_in     (s_a),
            .b_in     (s_b),
            .cin      (s_ci),
            .op       (s_op),
            .out_valid(s_ov),
            .out_ready(s_or),
            .sum      (s_sum),
            .cout     (s_co),
            .ovf      (s_of)
        );

        initial begin
            logic [65:0] exp_q [$];
            logic [65:0] e;
            int sent;
            int seen;
            sent  = 0;
            seen  = 0;
            s_rst = 1'b1;
            s_iv  = 1'b0;
            s_or  = 1'b0;
            s_a   = '0;
            s_b   = '0;
            s_ci  = 1'b0;
            s_op  = 2'b00;
            repeat (3) @(negedge clk);
            s_rst = 1'b0;
            for (int cyc = 0; cyc < 400 && (sent < 60 || exp_q.size() != 0); cyc++) begin
                @(negedge clk);
                s_iv = (sent < 60) && ($urandom_range(0, 3) != 0);
                s_or = ($urandom_range(0, 3) != 0);
                s_a  = SW'($urandom);
                s_b  = SW'($urandom);
                s_ci = 1'($urandom_range(0, 1));
                s_op = 2'($urandom_range(0, 3));
                #1;
                if (s_ov && s_or) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL sweep w%0d s%0d unexpected beat: got sum 0x%0h, required no beat", SW, SS, s_sum);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("sweep w%0d s%0d beat %0d", SW, SS, seen),
                              {s_co, s_of, 64'(s_sum)}, e);
                        seen++;
                    end
                end
                if (s_iv && s_ir) begin
                    exp_q.push_back(model(SW, 64'(s_a), 64'(s_b), s_ci, s_op));
                    sent++;
                end
            end
            s_iv = 1'b0;
            check($sformatf("sweep w%0d s%0d beats out", SW, SS), 66'(seen), 66'(60));
            sweeps_done++;
        end
    end

    initial begin
        int k;
        int got;
        logic [7:0] held;

        vecs[0]  = '{8'h3C, 8'h45, 1'b0, 2'b00, 8'h81, 1'b0, 1'b1};
        vecs[1]  = '{8'h05, 8'h07, 1'b0, 2'b01, 8'hFE, 1'b0, 1'b0};
        vecs[2]  = '{8'h80, 8'h01, 1'b0, 2'b01, 8'h7F, 1'b1, 1'b1};
        vecs[3]  = '{8'hFF, 8'h00, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{8'hFF, 8'h00, 1'b1, 2'b00, 8'hFF, 1'b0, 1'b0};
        vecs[5]  = '{8'h7F, 8'h01, 1'b0, 2'b11, 8'h7F, 1'b0, 1'b1};
        vecs[6]  = '{8'h80, 8'hFF, 1'b0, 2'b11, 8'h80, 1'b1, 1'b1};
        vecs[7]  = '{8'h10, 8'h20, 1'b0, 2'b11, 8'h30, 1'b0, 1'b0};
        vecs[8]  = '{8'hFF, 8'h01, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{8'h00, 8'h00, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{8'h7F, 8'h00, 1'b0, 2'b10, 8'h7F, 1'b0, 1'b0};
        vecs[11] = '{8'h7F, 8'hFF, 1'b0, 2'b01, 8'h80, 1'b0, 1'b1};
        vecs[12] = '{8'h7F, 8'h00, 1'b1, 2'b10, 8'h80, 1'b0, 1'b1};
        vecs[13] = '{8'hF0, 8'hF0, 1'b0, 2'b11, 8'hE0, 1'b1, 1'b0};
        vecs[14] = '{8'h05, 8'h03, 1'b1, 2'b01, 8'h02, 1'b1, 1'b0};
        vecs[15] = '{8'h10, 8'h20, 1'b1, 2'b11, 8'h30, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = 8'h5A;
        b_in      = 8'hA5;
        cin       = 1'b1;
        op        = 2'b10;
        repeat (3) @(negedge clk);
        check("reset out_valid", 66'(out_valid), 66'(0));
        check("reset sum", 66'(sum), 66'(0));
        check("reset cout/ovf", 66'({cout, ovf}), 66'(0));
        rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", 66'(in_ready), 66'(1));

        // Table vectors: one beat, then a bubble, with operands scrambled after accept.
        for (int i = 0; i < NV; i++) begin
            a_in      = vecs[i].a;
            b_in      = vecs[i].b;
            cin       = vecs[i].c;
            op        = vecs[i].o;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            a_in     = ~vecs[i].a;
            b_in     = ~vecs[i].b;
            cin      = ~vecs[i].c;
            op       = ~vecs[i].o;
            check($sformatf("vec%0d early valid", i), 66'(out_valid), 66'(0));
            @(negedge clk);
            check($sformatf("vec%0d out_valid", i), 66'(out_valid), 66'(1));
            check($sformatf("vec%0d {cout,ovf,sum}", i), 66'({cout, ovf, sum}),
                  66'({vecs[i].co, vecs[i].ov, vecs[i].s}));
            @(negedge clk);
            check($sformatf("vec%0d bubble valid/sum", i), 66'({out_valid, sum}), 66'({1'b0, vecs[i].s}));
        end

        // Backpressure: 8 beats i+i, out_ready low in cycles 3..5.
        k    = 0;
        got  = 0;
        held = 8'h00;
        for (int c = 0; c < 40 && got < 8; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (k < 8);
            a_in      = 8'(k);
            b_in      = 8'(k);
            op        = 2'b00;
            cin       = 1'b0;
            #1;
            if (!out_ready) begin
                check($sformatf("stall c%0d in_ready", c), 66'(in_ready), 66'(0));
                check($sformatf("stall c%0d out_valid", c), 66'(out_valid), 66'(1));
                if (c == 3) begin
                    held = sum;
                end else begin
                    check($sformatf("stall c%0d sum hold", c), 66'(sum), 66'(held));
                end
            end
            if (out_valid && out_ready) begin
                check($sformatf("stream beat %0d", got), 66'(sum), 66'(2 * got));
                got++;
            end
            if (in_valid && in_ready) begin
                k++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream results", 66'(got), 66'(8));
        check("stream accepted", 66'(k), 66'(8));
        @(negedge clk);
        check("stream drained", 66'(out_valid), 66'(0));

        // Reset with two beats in flight; neither may ever appear.
        in_valid = 1'b1;
        a_in     = 8'h11;
        b_in     = 8'h22;
        op       = 2'b00;
        @(negedge clk);
        a_in = 8'h33;
        b_in = 8'h44;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("mid reset out_valid", 66'(out_valid), 66'(0));
        check("mid reset sum", 66'(sum), 66'(0));
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("no stale beat %0d", i), 66'(out_valid), 66'(0));
        end
        in_valid = 1'b1;
        a_in     = 8'h21;
        b_in     = 8'h12;
        @(negedge clk);
        in_valid = 1'b0;
        check("post reset early valid", 66'(out_valid), 66'(0));
        @(negedge clk);
        check("post reset beat", 66'({out_valid, sum}), 66'({1'b1, 8'h33}));

        for (int t = 0; t < 3000 && sweeps_done < NCFG; t++) begin
            @(negedge clk);
        end
        check("sweeps finished", 66'(sweeps_done), 66'(NCFG));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prefix_adder_pipe.md
Name: prefix_adder_pipe

Overview:
- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor. It is the registered successor to the team's 8-bit combinational prefix adders.
- Adds configurable width and pipeline depth, an operation select (add, subtract, add-with-carry, signed saturating add), and carry-out/overflow flags.
- Uses a valid/ready handshake on both sides, so it sits between Wishbone-driven operand registers and downstream consumers in the user project.

Parameters:
- WIDTH, 8, operand/result width; power of two, 4..64.
- STAGES, 2, pipeline register ranks, 1..log2(WIDTH)+1; equals accept-to-output latency.
- SAT_EN, 1, 1 = op 2'b11 performs signed saturating add; 0 = op 2'b11 behaves as 2'b00.

Ports:
- wb_clk_i  in  1  clock; all state updates on rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- cin  in  1  carry-in, used only by op 2'b10
- op  in  2  00 add, 01 sub (A-B), 10 add A+B+cin, 11 signed saturating add
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  out  1  signed overflow (for op 11: saturation occurred)

Behaviour:
- Reset, synchronous active-high, on wb_clk_i only: every stage valid bit cleared; out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 from the first cycle after reset deasserts.
- Reset asserted mid-operation flushes all in-flight beats; no result for them is ever presented.
- Datapath: effective B' = ~b_in for sub, else b_in. Effective c0 = 1 for sub, cin for op 10, else 0.
  - Generate/propagate g=A&B', p=A^B'.
  - log2(WIDTH) Kogge-Stone prefix levels; the carry into bit i is G[i-1:0] | (P[i-1:0] & c0).
  - sum = p ^ carries; cout = carry out of bit WIDTH-1; ovf = carry into MSB XOR cout.
- Saturation (op 11, SAT_EN=1): if ovf=1 and A[MSB]=0 then sum = 0 followed by WIDTH-1 ones (max positive). If ovf=1 and A[MSB]=1 then sum = 1 followed by WIDTH-1 zeros (min negative). ovf=1 is reported in both cases; cout is the unsaturated carry.
- Pipeline: rank 1 registers operands, op and c0 at input acceptance. Remaining STAGES-1 ranks sit only on whole prefix-level boundaries, spread as evenly as possible. Each rank carries its valid bit with the data.
- Latency: a beat accepted at edge N gives out_valid=1 after edge N+STAGES-1 when there is no stall. For STAGES=1, the result is visible the cycle after acceptance.
- Handshake:
  - advance = out_ready | ~out_valid; in_ready = advance (combinational from out_ready and state).
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - While advance=0 all ranks hold, and sum/cout/ovf are stable with out_valid held high.
  - Bubbles are not compressed: the whole pipeline moves as one unit.
- Throughput: one beat per cycle with out_ready held high.
- Ordering: results leave strictly in acceptance order.
- Boundaries:
  - in_valid=0 while advancing inserts a bubble (valid=0 propagates; sum keeps its last value).
  - Simultaneous accept and emit in the same cycle is legal and is the steady state.
  - op and cin are sampled only on an accepted beat.
- Width rules: all arithmetic is modulo 2^WIDTH; no X propagation from unused cin.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: accept A=0x3C, B=0x45, op=00 at edge 0 -> out_valid=1 after edge 1, sum=0x81, cout=0, ovf=1.
- op=01, A=0x05, B=0x07 -> sum=0xFE, cout=0, ovf=0. Then A=0x80, B=0x01 -> sum=0x7F, cout=1, ovf=1.
- op=10, A=0xFF, B=0x00, cin=1 -> sum=0x00, cout=1, ovf=0. Same operands with op=00 and cin=1 -> sum=0xFF (cin ignored).
- op=11, SAT_EN=1: A=0x7F, B=0x01 -> sum=0x7F, ovf=1; A=0x80, B=0xFF -> sum=0x80, ovf=1; A=0x10, B=0x20 -> sum=0x30, ovf=0.
- Backpressure: stream 8 back-to-back adds i+i (i=0..7), out_ready low for cycles 3-5.
  - While stalled, in_ready=0 and out_valid/sum hold.
  - All 8 results arrive in order (0x00,0x02,...,0x0E), none lost or duplicated.
- Reset mid-stream with 2 beats in flight -> next cycle out_valid=0, sum=0. No stale beat appears. A new beat after reset returns with exactly STAGES-cycle latency.
- Random sweep over WIDTH in {4,8,32} and STAGES from 1 to max, against a behavioural model -> zero mismatches.
